// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: lock FSM encodings and shared widths
// for the clk_div_bank clock generator.
package clk_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } lock_state_t;

  localparam int CHAN_IDX_W  = 3;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divided-clock channel with shadow
// config that is swapped in only at period boundaries.
module clk_div_chan
  import clk_gen_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 wr,
  input  logic [DIV_WIDTH-1:0] wr_div,
  input  logic [DIV_WIDTH:0]   wr_phase,
  input  logic                 wr_en,
  output logic                 pending,
  output logic                 clk_out,
  output logic                 rise_stb
);

  localparam int CW = DIV_WIDTH + 1;

  logic [DIV_WIDTH-1:0] sh_div;
  logic [DIV_WIDTH-1:0] act_div;
  logic [DIV_WIDTH-1:0] nxt_div;
  logic [CW-1:0]        sh_phase;
  logic [CW-1:0]        act_phase;
  logic [CW-1:0]        nxt_phase;
  logic [CW-1:0]        phase_eff;
  logic [CW-1:0]        period;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_n;
  logic                 sh_en;
  logic                 act_en;
  logic                 nxt_en;
  logic                 live_q;
  logic                 nxt_live;
  logic                 wrap;
  logic                 apply;
  logic                 accept;
  logic                 clk_n;

  always_comb begin
    period    = {act_div, 1'b0};
    wrap      = live_q && (cnt == period - CW'(1));
    // an idle channel takes a new config on the very next edge
    apply     = pending && (!live_q || wrap);
    accept    = wr && !pending;
    nxt_div   = apply ? sh_div   : act_div;
    nxt_phase = apply ? sh_phase : act_phase;
    nxt_en    = apply ? sh_en    : act_en;
    nxt_live  = run && nxt_en && (nxt_div != '0);
    phase_eff = (nxt_phase < {nxt_div, 1'b0}) ? nxt_phase : '0;
    if (!nxt_live) begin
      cnt_n = '0;
    end else if (!live_q || apply) begin
      cnt_n = phase_eff;
    end else if (wrap) begin
      cnt_n = '0;
    end else begin
      cnt_n = cnt + CW'(1);
    end
    clk_n = nxt_live && (cnt_n < {1'b0, nxt_div});
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sh_div    <= '0;
      sh_phase  <= '0;
      sh_en     <= 1'b0;
      act_div   <= '0;
      act_phase <= '0;
      act_en    <= 1'b0;
      pending   <= 1'b0;
      live_q    <= 1'b0;
      cnt       <= '0;
      clk_out   <= 1'b0;
      rise_stb  <= 1'b0;
    end else begin
      if (accept) begin
        sh_div   <= wr_div;
        sh_phase <= wr_phase;
        sh_en    <= wr_en;
      end
      if (apply) begin
        act_div   <= sh_div;
        act_phase <= sh_phase;
        act_en    <= sh_en;
      end
      pending  <= apply ? 1'b0 : (pending | accept);
      live_q   <= nxt_live;
      cnt      <= cnt_n;
      clk_out  <= clk_n;
      rise_stb <= clk_n & ~clk_out;
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: PLL lock qualifier plus a bank of
// independently configurable divided clocks.
module clk_div_bank
  import clk_gen_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_IDX_W-1:0] cfg_chan,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [DIV_WIDTH:0]    cfg_phase,
  input  logic                  cfg_en,
  output logic                  ready,
  output logic [CHANNELS-1:0]   clk_out,
  output logic [CHANNELS-1:0]   rise_stb
);

  localparam int SW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_CYCLES - 1);

  lock_state_t            state_q;
  lock_state_t            state_n;
  logic [SW-1:0]          settle_q;
  logic [SW-1:0]          settle_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   run;
  logic [CHANNELS-1:0]    pending;
  logic [CHANNELS-1:0]    wr;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_LOCK;
      settle_q <= '0;
    end else begin
      state_q  <= state_n;
      settle_q <= settle_n;
    end
  end

  // the high seen in WAIT_LOCK counts as the first settle cycle
  always_comb begin
    state_n  = state_q;
    settle_n = '0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          settle_n = SW'(1);
          if (LOCK_CYCLES <= 1) begin
            state_n = RUN;
          end else begin
            state_n = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
        end else if (settle_q == SETTLE_LAST) begin
          state_n = RUN;
        end else begin
          settle_n = settle_q + SW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
        end
      end
      default: state_n = WAIT_LOCK;
    endcase
  end

  always_comb begin
    ready = (state_q == RUN);
    run   = (state_n == RUN);
  end

  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CHAN_IDX_W'(i)) begin
        cfg_ready = ~pending[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign wr[g] = cfg_valid && (cfg_chan == CHAN_IDX_W'(g));

    clk_div_chan #(
      .DIV_WIDTH(DIV_WIDTH)
    ) u_chan (
      .clk_in   (clk_in),
      .rst      (rst),
      .run      (run),
      .wr       (wr[g]),
      .wr_div   (cfg_div),
      .wr_phase (cfg_phase),
      .wr_en    (cfg_en),
      .pending  (pending[g]),
      .clk_out  (clk_out[g]),
      .rise_stb (rise_stb[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed scenarios plus randomized
// config/lock traffic against a period-position model.
module tb_clk_div_bank;

  localparam int CH = 2;
  localparam int DW = 8;
  localparam int PW = DW + 1;
  localparam int LC = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_chan;
  logic [DW-1:0] cfg_div;
  logic [PW-1:0] cfg_phase;
  logic          cfg_en;
  logic          ready;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] rise_stb;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  clk_div_bank #(
    .CHANNELS(CH),
    .DIV_WIDTH(DW),
    .LOCK_CYCLES(LC)
  ) dut (
    .clk_in    (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .cfg_en    (cfg_en),
    .ready     (ready),
    .clk_out   (clk_out),
    .rise_stb  (rise_stb)
  );

  // model: lock history, shadow/active configs, position in period
  int pll_hist[$];
  int streak;
  bit m_run;
  int m_sdiv[CH];
  int m_sph[CH];
  bit m_sen[CH];
  int m_adiv[CH];
  int m_aph[CH];
  bit m_aen[CH];
  bit m_pend[CH];
  bit m_live[CH];
  int m_pos[CH];
  bit m_clk[CH];
  bit m_rise[CH];

  int rq0[$];
  int rq1[$];
  int hq0[$];
  int hq1[$];
  int hi_cnt[CH];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pll_hist = {};
    pll_hist.push_back(0);
    pll_hist.push_back(0);
    streak = 0;
    m_run  = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_sdiv[i] = 0; m_sph[i] = 0; m_sen[i] = 1'b0;
      m_adiv[i] = 0; m_aph[i] = 0; m_aen[i] = 1'b0;
      m_pend[i] = 1'b0; m_live[i] = 1'b0;
      m_pos[i] = 0; m_clk[i] = 1'b0; m_rise[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    int  s;
    int  pos;
    bit  at_end;
    bit  ap;
    bit  lv;
    bit  nclk;
    bit  acc[CH];
    if (rst) begin
      model_reset();
      return;
    end
    s = pll_hist.pop_front();
    pll_hist.push_back(int'(pll_locked));
    streak = (s != 0) ? ((streak < 100000) ? streak + 1 : streak) : 0;
    m_run = (streak >= LC);
    for (int i = 0; i < CH; i++) begin
      acc[i] = cfg_valid && (int'(cfg_chan) == i) && !m_pend[i];
    end
    for (int i = 0; i < CH; i++) begin
      at_end = m_live[i] && (m_pos[i] == 2 * m_adiv[i] - 1);
      ap = m_pend[i] && (!m_live[i] || at_end);
      if (ap) begin
        m_adiv[i] = m_sdiv[i];
        m_aph[i]  = m_sph[i];
        m_aen[i]  = m_sen[i];
        m_pend[i] = 1'b0;
      end
      lv = m_run && m_aen[i] && (m_adiv[i] != 0);
      if (!lv) pos = 0;
      else if (!m_live[i] || ap)
        pos = (m_aph[i] < 2 * m_adiv[i]) ? m_aph[i] : 0;
      else pos = (m_pos[i] + 1) % (2 * m_adiv[i]);
      nclk = lv && (pos < m_adiv[i]);
      m_rise[i] = nclk && !m_clk[i];
      m_clk[i]  = nclk;
      m_pos[i]  = pos;
      m_live[i] = lv;
      if (acc[i]) begin
        m_sdiv[i] = int'(cfg_div);
        m_sph[i]  = int'(cfg_phase);
        m_sen[i]  = cfg_en;
        m_pend[i] = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // per-cycle compare and edge monitor, mid-cycle
  initial begin
    logic [CH-1:0] e_clk;
    logic [CH-1:0] e_rise;
    bit            e_rdy;
    for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < CH; i++) begin
        e_clk[i]  = m_clk[i];
        e_rise[i] = m_rise[i];
      end
      e_rdy = (int'(cfg_chan) >= CH) ? 1'b1 : !m_pend[cfg_chan[0]];
      chk("ready", int'(ready), int'(m_run));
      chk("clk_out", int'(clk_out), int'(e_clk));
      chk("rise_stb", int'(rise_stb), int'(e_rise));
      chk("cfg_ready", int'(cfg_ready), int'(e_rdy));
      for (int i = 0; i < CH; i++) begin
        if (rise_stb[i]) begin
          if (i == 0) rq0.push_back(cyc);
          else rq1.push_back(cyc);
        end
        if (clk_out[i]) begin
          hi_cnt[i]++;
        end else if (hi_cnt[i] > 0) begin
          if (i == 0) hq0.push_back(hi_cnt[i]);
          else hq1.push_back(hi_cnt[i]);
          hi_cnt[i] = 0;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input int ch, input int dv,
                           input int ph, input bit e);
    int n = 0;
    @(posedge clk);
    #1;
    cfg_valid = 1'b1;
    cfg_chan  = 3'(ch);
    cfg_div   = DW'(dv);
    cfg_phase = PW'(ph);
    cfg_en    = e;
    while (!cfg_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("cfg_wait_timeout", n, 0);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    pll_locked = 1'b0;
    cfg_valid  = 1'b0;
    cfg_chan   = '0;
    cfg_div    = '0;
    cfg_phase  = '0;
    cfg_en     = 1'b0;
    cycles(3);
    rst = 1'b0;

    // reset state
    @(negedge clk);
    #1;
    chk("rst_ready", int'(ready), 0);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);

    // lock qualification latency: 2 sync + LC settle edges
    cycles(2);
    pll_locked = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready && n < 100);
    chk("lock_latency", n, LC + 2);
    chk("run_clk_idle", int'(clk_out), 0);

    // div=3: period 6, high 3
    cfg_write(0, 3, 0, 1'b1);
    rq0.delete();
    hq0.delete();
    cycles(40);
    chk("div3_rises", int'(rq0.size() >= 5), 1);
    if (rq0.size() >= 4) begin
      chk("div3_per_a", rq0[1] - rq0[0], 6);
      chk("div3_per_b", rq0[2] - rq0[1], 6);
      chk("div3_per_c", rq0[3] - rq0[2], 6);
    end
    if (hq0.size() >= 3) begin
      chk("div3_high_a", hq0[1], 3);
      chk("div3_high_b", hq0[2], 3);
    end

    // reconfigure to div=5 mid-period
    rq0.delete();
    n = 0;
    while (rq0.size() == 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    hq0.delete();
    cfg_write(0, 5, 0, 1'b1);
    chk("reconf_ready_low", int'(cfg_ready), 0);
    cycles(40);
    chk("reconf_rises", int'(rq0.size() >= 4), 1);
    if (rq0.size() >= 4) begin
      chk("reconf_old_per", rq0[1] - rq0[0], 6);
      chk("reconf_new_per_a", rq0[2] - rq0[1], 10);
      chk("reconf_new_per_b", rq0[3] - rq0[2], 10);
    end
    if (hq0.size() >= 2) begin
      chk("reconf_high_old", hq0[0], 3);
      chk("reconf_high_new", hq0[1], 5);
    end
    foreach (hq0[k]) chk("reconf_no_runt", int'(hq0[k] >= 3), 1);

    // drop lock while high
    n = 0;
    while (!clk_out[0] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    pll_locked = 1'b0;
    cycles(2);
    chk("unlock_ready_e2", int'(ready), 1);
    cycles(1);
    chk("unlock_ready_e3", int'(ready), 0);
    chk("unlock_clk_e3", int'(clk_out), 0);

    // phase offset and out-of-range channel, then relock
    cfg_write(0, 2, 0, 1'b1);
    cfg_write(1, 2, 2, 1'b1);
    cfg_chan = 3'd7;
    #1;
    chk("chan7_ready", int'(cfg_ready), 1);
    cfg_write(7, 9, 3, 1'b1);
    rq0.delete();
    rq1.delete();
    pll_locked = 1'b1;
    cycles(60);
    chk("relock_ready", int'(ready), 1);
    if (rq0.size() >= 2 && rq1.size() >= 2) begin
      chk("lag_ch1", rq1[0] - rq0[0], 2);
      chk("per_ch0", rq0[1] - rq0[0], 4);
      chk("per_ch1", rq1[1] - rq1[0], 4);
    end else begin
      chk("relock_rises", int'(rq0.size() >= 2 && rq1.size() >= 2), 1);
    end

    // reset while ch1 has a pending request
    cfg_write(1, 4, 0, 1'b1);
    chk("pend_ch1_ready", int'(cfg_ready), 0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_clk_out", int'(clk_out), 0);
    chk("arst_rise", int'(rise_stb), 0);
    chk("arst_ready", int'(ready), 0);
    chk("arst_cfg_ready", int'(cfg_ready), 1);
    cycles(2);
    rst = 1'b0;
    rq0.delete();
    rq1.delete();
    cycles(50);
    chk("post_rst_ready", int'(ready), 1);
    chk("post_rst_ch0_off", rq0.size(), 0);
    chk("post_rst_ch1_off", rq1.size(), 0);

    // randomized traffic, checked every cycle by the model
    for (int k = 0; k < 2500; k++) begin
      @(posedge clk);
      #1;
      if (rst) rst = 1'b0;
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_chan  = 3'($urandom_range(0, 3));
      cfg_div   = DW'($urandom_range(0, 5));
      cfg_phase = PW'($urandom_range(0, 11));
      cfg_en    = ($urandom_range(0, 3) != 0);
      if (pll_locked) begin
        if ($urandom_range(0, 299) == 0) pll_locked = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        pll_locked = 1'b1;
      end
      if ($urandom_range(0, 799) == 0) rst = 1'b1;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cfg_valid = 1'b0;
    cycles(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
